// File: rtl/plot_capture.sv
// plot_capture: buffers a pixel-write stream in a 16-entry FIFO and drains it into a
// 160x120x9 frame store, sharing the single memory port with a one-at-a-time read port.
module plot_capture (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] iX,
    input  logic [6:0] iY,
    input  logic [8:0] iColour,
    input  logic       iPlot,
    output logic       oReady,
    input  logic       rdReq,
    input  logic [7:0] rdX,
    input  logic [6:0] rdY,
    output logic       rdBusy,
    output logic       rdValid,
    output logic [8:0] rdColour,
    output logic [7:0] oDropCount,
    output logic [4:0] oFifoLevel,
    output logic       oClearing
);

    localparam int unsigned XW    = 8;
    localparam int unsigned YW    = 7;
    localparam int unsigned CW    = 9;
    localparam int unsigned AW    = 15;
    localparam int unsigned XMAX  = 160;
    localparam int unsigned YMAX  = 120;
    localparam int unsigned NPIX  = 19200;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 4;
    localparam int unsigned LW    = 5;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] colour;
    } plot_t;

    // y*160 + x built from shifts; the largest address (19199) fits in 15 bits
    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'({y, 7'd0}) + AW'({y, 5'd0}) + AW'(x);
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q;
    plot_t         fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          ready_q, busy_q, valid_q, zero_q, clearing_q;
    logic          rd_pend_q, rd_pend_d, rd_valid_d;
    logic [AW-1:0] rd_addr_q;
    logic          last_wr_q;
    logic [7:0]    drop_q;
    logic [CW-1:0] mem_q [NPIX];
    logic [CW-1:0] mem_rdata_q;

    logic          plot_in_range, rd_in_range, push, rd_acc, running, clearing_now;
    logic          fifo_empty, gnt_rd, gnt_wr, mem_we;
    plot_t         head;
    logic [AW-1:0] mem_waddr;
    logic [CW-1:0] mem_wdata;

    // Acceptance, memory-port arbitration and next-state decode
    always_comb begin
        plot_in_range = (iX < XW'(XMAX)) && (iY < YW'(YMAX));
        rd_in_range   = (rdX < XW'(XMAX)) && (rdY < YW'(YMAX));
        push          = iPlot & ready_q & plot_in_range & ~reset;
        rd_acc        = rdReq & ~busy_q & ~reset;
        running       = (state_q == ST_RUN) & ~reset;
        clearing_now  = (state_q == ST_CLEAR) & ~reset;
        fifo_empty    = (level_q == '0);
        gnt_rd        = running & rd_pend_q & (fifo_empty | last_wr_q);
        gnt_wr        = running & ~gnt_rd & ~fifo_empty;
        head          = fifo_q[rd_ptr_q];
        mem_we        = clearing_now | gnt_wr;
        mem_waddr     = clearing_now ? clr_addr_q : pix_addr(head.x, head.y);
        mem_wdata     = clearing_now ? '0 : head.colour;

        state_d = state_q;
        if (clearing_now && (clr_addr_q == AW'(NPIX - 1))) begin
            state_d = ST_RUN;
        end

        level_d = LW'(level_q + LW'(push) - LW'(gnt_wr));

        rd_pend_d = rd_pend_q;
        if (rd_acc && rd_in_range) begin
            rd_pend_d = 1'b1;
        end else if (gnt_rd) begin
            rd_pend_d = 1'b0;
        end
        rd_valid_d = gnt_rd | (rd_acc & ~rd_in_range);
    end

    // Control state, FIFO pointers, read tracking and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            valid_q    <= 1'b0;
            zero_q     <= 1'b1;
            last_wr_q  <= 1'b0;
            drop_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            clearing_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clearing_now ? AW'(clr_addr_q + 1'b1) : '0;
            wr_ptr_q   <= PW'(wr_ptr_q + PW'(push));
            rd_ptr_q   <= PW'(rd_ptr_q + PW'(gnt_wr));
            level_q    <= level_d;
            rd_pend_q  <= rd_pend_d;
            if (rd_acc) begin
                rd_addr_q <= pix_addr(rdX, rdY);
            end
            valid_q <= rd_valid_d;
            // out-of-range reads report zero without touching memory
            if (rd_acc && !rd_in_range) begin
                zero_q <= 1'b1;
            end else if (gnt_rd) begin
                zero_q <= 1'b0;
            end
            if (gnt_wr) begin
                last_wr_q <= 1'b1;
            end else if (gnt_rd) begin
                last_wr_q <= 1'b0;
            end
            if (iPlot && !push && (drop_q != '1)) begin
                drop_q <= 8'(drop_q + 8'd1);
            end
            ready_q    <= (state_d == ST_RUN) && (level_d != LW'(DEPTH));
            busy_q     <= (state_d == ST_CLEAR) | rd_pend_d | rd_valid_d;
            clearing_q <= (state_d == ST_CLEAR);
        end
    end

    // FIFO storage and frame memory: one memory access per cycle, synchronous read
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{x: iX, y: iY, colour: iColour};
        end
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        if (gnt_rd) begin
            mem_rdata_q <= mem_q[rd_addr_q];
        end
    end

    assign oReady     = ready_q;
    assign rdBusy     = busy_q;
    assign rdValid    = valid_q;
    assign rdColour   = mem_rdata_q & {CW{~zero_q}};
    assign oDropCount = drop_q;
    assign oFifoLevel = level_q;
    assign oClearing  = clearing_q;

endmodule

// File: doc/plot_capture.md
PLOT_CAPTURE -- requirements
Module: plot_capture

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock  in  1  system clock (50 MHz), all logic on rising edge; reset  in  1  synchronous active-high reset.
REQ-002 SHALL accept the pixel-write stream: iX  in  8  column; iY  in  7  row; iColour  in  9  RGB 3:3:3; iPlot  in  1  write strobe, one pixel per high cycle.
REQ-003 SHALL output oReady  out  1  high when a plot is accepted this cycle.
REQ-004 SHALL provide a read port: rdReq  in  1; rdX  in  8; rdY  in  7; rdBusy  out  1; rdValid  out  1; rdColour  out  9.
REQ-005 SHALL output status: oDropCount  out  8  dropped plots, saturating; oFifoLevel  out  5  FIFO occupancy, 0..16; oClearing  out  1  clear sweep active.

Function
REQ-006 SHALL hold a 19200 x 9 frame memory: 160x120, address = y*160 + x, single access per cycle, 1-cycle synchronous read.
REQ-007 SHALL use states CLEAR and RUN: reset -> CLEAR; CLEAR -> RUN after writing address 19199.
REQ-008 In CLEAR, SHALL write 0 to addresses 0..19199, one per cycle in ascending order, taking 19200 cycles.
REQ-009 In CLEAR, SHALL drive oReady=0, rdBusy=1 and oClearing=1; SHALL accept no plots or reads.
REQ-010 SHALL buffer plots in a 16-entry FIFO holding {x,y,colour}, with oReady = RUN and FIFO not full, taken from registered state.
REQ-011 SHALL push when iPlot=1, oReady=1, iX<160 and iY<120.
REQ-012 SHALL drop a plot and increment oDropCount (saturating at 255) when iPlot=1 and either oReady=0 or the coordinate is out of range.
REQ-013 When FIFO is full and a pop occurs in the same cycle, SHALL still reject the push.
REQ-014 SHALL accept a read when rdReq=1 and rdBusy=0, latching rdX/rdY; rdBusy SHALL be 1 from the next cycle until the rdValid cycle inclusive.
REQ-015 SHALL arbitrate each RUN cycle: a pending read wins if FIFO is empty or the previous grant was a write; otherwise the FIFO head is written and popped.
REQ-016 SHALL therefore wait at most 2 cycles between read acceptance and read grant.
REQ-017 SHALL pulse rdValid for exactly 1 cycle, in the cycle after the read grant.
REQ-018 SHALL hold rdColour stable until the next rdValid.
REQ-019 For an out-of-range read (rdX>=160 or rdY>=120), SHALL use no memory access and SHALL pulse rdValid the cycle after acceptance with rdColour=0.
REQ-020 A read of a pixel whose write is still in the FIFO SHALL return the old memory value; no bypass is provided.
REQ-021 SHALL update oFifoLevel every cycle: +1 on push, -1 on pop, unchanged when both occur.
REQ-022 SHALL compute the address as y*160 = (y<<7)+(y<<5) plus x, in 15 bits with no overflow.

Reset
REQ-023 reset=1 SHALL force on the next edge:
  - state=CLEAR, clear address 0;
  - FIFO empty, oFifoLevel=0;
  - pending read discarded;
  - rdValid=0, rdColour=0;
  - oDropCount=0;
  - oReady=0, rdBusy=1, oClearing=1;
  - last-grant=read.
REQ-024 Reset asserted mid-operation (mid-CLEAR, or FIFO non-empty) SHALL abandon all work and restart the CLEAR sweep from address 0.

Verification
REQ-025 Reset, then idle -> oClearing=1 for 19200 cycles, then oReady=1; a read of (159,119) returns rdColour=0.
REQ-026 After CLEAR, plot (10,20,9'h1C7) then read (10,20) -> rdValid within 3 cycles of acceptance, rdColour=9'h1C7.
REQ-027 After CLEAR, 20 back-to-back plots with no drain stall (reads held busy) -> at most 16 accepted, oReady=0 at level 16, oDropCount counts the rest.
REQ-028 Plot at (160,0) and at (0,120) -> both dropped, oDropCount +2, oFifoLevel unchanged; read of (200,5) -> rdValid next cycle, rdColour=0.
REQ-029 FIFO kept non-empty while rdReq pulses -> every read completes within 3 cycles and writes alternate with reads.
REQ-030 Assert reset with 8 entries queued and a read pending -> oFifoLevel=0, no rdValid, sweep restarts at address 0.
